// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared op codes, stage codes and sequencer state encodings for the
// TickTockTokens scheduler.
package tt_um_jleugeri_ttt_pkg;

    typedef enum logic [3:0] {
        OP_NOP         = 4'b0000,
        OP_INPUT       = 4'b0001,
        OP_ADVANCE     = 4'b0010,
        OP_PROG_DUR    = 4'b1000,
        OP_PROG_GTH    = 4'b1001,
        OP_PROG_BTH    = 4'b1010,
        OP_PROG_GW     = 4'b1011,
        OP_PROG_BW     = 4'b1100,
        OP_PROG_INDPTR = 4'b1101,
        OP_PROG_IDX    = 4'b1110
    } op_t;

    typedef enum logic [1:0] {
        STAGE_WAIT     = 2'b00,
        STAGE_UPDATE   = 2'b01,
        STAGE_CHECK    = 2'b10,
        STAGE_TRANSMIT = 2'b11
    } stage_t;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_UPDATE  = 3'd1,
        S_CHECK   = 3'd2,
        S_TX_LO   = 3'd3,
        S_TX_HI   = 3'd4,
        S_TX_END  = 3'd5,
        S_TX_WALK = 3'd6
    } state_t;

    function automatic logic is_prog_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_csr_walker.sv
// Walks the CSR fan-out of one firing processor: reads indptr[p] and
// indptr[p+1], then issues one connection read per slot in [lo, hi).
module tt_um_jleugeri_ttt_csr_walker
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter int PID_W           = 3,
    parameter int CID_W           = 4,
    parameter int NUM_CONNECTIONS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PID_W-1:0] base_idx,
    input  logic [CID_W-1:0] indptr_data,
    output logic             indptr_rd_en,
    output logic [PID_W-1:0] indptr_addr,
    output logic             conn_rd_en,
    output logic [CID_W-1:0] conn_idx,
    output logic             done
);

    state_t           phase_r;
    logic [CID_W-1:0] lo_r;
    logic [CID_W-1:0] hi_r;
    logic [CID_W-1:0] ptr_r;
    logic [CID_W-1:0] hi_clamp_s;
    logic             empty_s;
    logic             last_conn_s;

    // Clamp the upper pointer so a misprogrammed table never addresses past memory.
    always_comb begin
        if (indptr_data > CID_W'(NUM_CONNECTIONS)) begin
            hi_clamp_s = CID_W'(NUM_CONNECTIONS);
        end else begin
            hi_clamp_s = indptr_data;
        end
        empty_s     = (hi_clamp_s <= lo_r);
        last_conn_s = (ptr_r == (hi_r - CID_W'(1)));
    end

    // Read strobes and the completion pulse decoded from the walk phase.
    always_comb begin
        indptr_rd_en = 1'b0;
        indptr_addr  = {PID_W{1'b0}};
        conn_rd_en   = 1'b0;
        conn_idx     = {CID_W{1'b0}};
        done         = 1'b0;
        case (phase_r)
            S_TX_LO: begin
                indptr_rd_en = 1'b1;
                indptr_addr  = base_idx;
            end
            S_TX_HI: begin
                indptr_rd_en = 1'b1;
                indptr_addr  = base_idx + PID_W'(1);
            end
            S_TX_END: begin
                done = empty_s;
            end
            S_TX_WALK: begin
                conn_rd_en = 1'b1;
                conn_idx   = ptr_r;
                done       = last_conn_s;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // Walk phase sequencing and pointer registers; S_WAIT doubles as idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= S_WAIT;
            lo_r    <= {CID_W{1'b0}};
            hi_r    <= {CID_W{1'b0}};
            ptr_r   <= {CID_W{1'b0}};
        end else begin
            case (phase_r)
                S_TX_LO: begin
                    phase_r <= S_TX_HI;
                end
                S_TX_HI: begin
                    lo_r    <= indptr_data;
                    phase_r <= S_TX_END;
                end
                S_TX_END: begin
                    hi_r    <= hi_clamp_s;
                    ptr_r   <= lo_r;
                    phase_r <= empty_s ? S_WAIT : S_TX_WALK;
                end
                S_TX_WALK: begin
                    ptr_r   <= ptr_r + CID_W'(1);
                    phase_r <= last_conn_s ? S_WAIT : S_TX_WALK;
                end
                default: begin
                    phase_r <= start ? S_TX_LO : S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Stage sequencer for the TickTockTokens core: gates programming/input
// writes in WAIT and runs update, check and token-transmit rounds.
module tt_um_jleugeri_ttt_scheduler
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 4,
    parameter int NUM_CONNECTIONS = 12,
    localparam int PID_W = $clog2(NUM_PROCESSORS + 1),
    localparam int CID_W = $clog2(NUM_CONNECTIONS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       instruction,
    output logic             prog_en,
    output logic             ext_input_en,
    output logic [1:0]       stage,
    output logic [PID_W-1:0] proc_idx,
    output logic             proc_update_en,
    output logic             proc_check_en,
    input  logic [1:0]       startstop_in,
    output logic             indptr_rd_en,
    output logic [PID_W-1:0] indptr_addr,
    input  logic [CID_W-1:0] indptr_data,
    output logic             conn_rd_en,
    output logic [CID_W-1:0] conn_idx,
    output logic             out_valid,
    output logic [PID_W-1:0] out_proc,
    output logic [1:0]       out_startstop,
    output logic             round_done
);

    // S_TX_LO marks the whole transmit window; the walker owns the sub-phases.
    state_t           state_r;
    logic [PID_W-1:0] proc_idx_r;
    logic             out_valid_r;
    logic [PID_W-1:0] out_proc_r;
    logic [1:0]       out_ss_r;
    logic             round_done_r;
    logic             last_proc_s;
    logic             fire_s;
    logic             walk_done_s;

    assign last_proc_s = (proc_idx_r == PID_W'(NUM_PROCESSORS - 1));
    assign fire_s      = (state_r == S_CHECK) && (startstop_in != 2'b00);

    tt_um_jleugeri_ttt_csr_walker #(
        .PID_W           (PID_W),
        .CID_W           (CID_W),
        .NUM_CONNECTIONS (NUM_CONNECTIONS)
    ) u_walker (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (fire_s),
        .base_idx     (proc_idx_r),
        .indptr_data  (indptr_data),
        .indptr_rd_en (indptr_rd_en),
        .indptr_addr  (indptr_addr),
        .conn_rd_en   (conn_rd_en),
        .conn_idx     (conn_idx),
        .done         (walk_done_s)
    );

    // Stage code, per-processor strobes and WAIT-only write gating.
    always_comb begin
        proc_update_en = (state_r == S_UPDATE);
        proc_check_en  = (state_r == S_CHECK);
        prog_en        = (state_r == S_WAIT) && is_prog_op(instruction);
        ext_input_en   = (state_r == S_WAIT) && (instruction == OP_INPUT);
        case (state_r)
            S_WAIT:   stage = STAGE_WAIT;
            S_UPDATE: stage = STAGE_UPDATE;
            S_CHECK:  stage = STAGE_CHECK;
            S_TX_LO, S_TX_HI, S_TX_END, S_TX_WALK: stage = STAGE_TRANSMIT;
            default:  stage = STAGE_WAIT;
        endcase
    end

    assign proc_idx      = proc_idx_r;
    assign out_valid     = out_valid_r;
    assign out_proc      = out_proc_r;
    assign out_startstop = out_ss_r;
    assign round_done    = round_done_r;

    // Round sequencer with registered event and round-completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_WAIT;
            proc_idx_r   <= {PID_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_proc_r   <= {PID_W{1'b0}};
            out_ss_r     <= 2'b00;
            round_done_r <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            round_done_r <= 1'b0;
            case (state_r)
                S_WAIT: begin
                    if (instruction == OP_ADVANCE) begin
                        state_r    <= S_UPDATE;
                        proc_idx_r <= {PID_W{1'b0}};
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_UPDATE: begin
                    if (last_proc_s) begin
                        state_r    <= S_CHECK;
                        proc_idx_r <= {PID_W{1'b0}};
                    end else begin
                        proc_idx_r <= proc_idx_r + PID_W'(1);
                    end
                end
                S_CHECK: begin
                    if (fire_s) begin
                        out_valid_r <= 1'b1;
                        out_proc_r  <= proc_idx_r;
                        out_ss_r    <= startstop_in;
                        state_r     <= S_TX_LO;
                    end else if (last_proc_s) begin
                        state_r      <= S_WAIT;
                        proc_idx_r   <= {PID_W{1'b0}};
                        round_done_r <= 1'b1;
                    end else begin
                        proc_idx_r <= proc_idx_r + PID_W'(1);
                    end
                end
                S_TX_LO: begin
                    if (walk_done_s && last_proc_s) begin
                        state_r      <= S_WAIT;
                        proc_idx_r   <= {PID_W{1'b0}};
                        round_done_r <= 1'b1;
                    end else if (walk_done_s) begin
                        state_r    <= S_CHECK;
                        proc_idx_r <= proc_idx_r + PID_W'(1);
                    end else begin
                        state_r <= S_TX_LO;
                    end
                end
                default: begin
                    state_r    <= S_WAIT;
                    proc_idx_r <= {PID_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Directed bench for the TickTockTokens scheduler with a small indptr
// memory model and a startstop reply table.
module tb_tt_um_jleugeri_ttt_scheduler;

    localparam int PID_W = 3;
    localparam int CID_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       instruction = 4'b0000;
    logic             prog_en, ext_input_en;
    logic [1:0]       stage;
    logic [PID_W-1:0] proc_idx;
    logic             proc_update_en, proc_check_en;
    logic [1:0]       startstop_in;
    logic             indptr_rd_en;
    logic [PID_W-1:0] indptr_addr;
    logic [CID_W-1:0] indptr_data = 4'd0;
    logic             conn_rd_en;
    logic [CID_W-1:0] conn_idx;
    logic             out_valid;
    logic [PID_W-1:0] out_proc;
    logic [1:0]       out_startstop;
    logic             round_done;

    logic [CID_W-1:0] indptr_mem [0:7];
    logic [1:0]       ss_tbl [0:7];
    logic [7:0]       ctl;
    logic [7:0]       exp_ctl;
    int               n_cmp = 0;
    int               n_err = 0;

    tt_um_jleugeri_ttt_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction    (instruction),
        .prog_en        (prog_en),
        .ext_input_en   (ext_input_en),
        .stage          (stage),
        .proc_idx       (proc_idx),
        .proc_update_en (proc_update_en),
        .proc_check_en  (proc_check_en),
        .startstop_in   (startstop_in),
        .indptr_rd_en   (indptr_rd_en),
        .indptr_addr    (indptr_addr),
        .indptr_data    (indptr_data),
        .conn_rd_en     (conn_rd_en),
        .conn_idx       (conn_idx),
        .out_valid      (out_valid),
        .out_proc       (out_proc),
        .out_startstop  (out_startstop),
        .round_done     (round_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (indptr_rd_en) indptr_data <= indptr_mem[indptr_addr];
    end

    assign startstop_in = proc_check_en ? ss_tbl[proc_idx] : 2'b00;
    assign ctl = {stage, proc_update_en, proc_check_en, indptr_rd_en, conn_rd_en, out_valid, round_done};

    task automatic clear_tables();
        for (int i = 0; i < 8; i++) begin
            indptr_mem[i] = 4'd0;
            ss_tbl[i]     = 2'b00;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue ADVANCE in WAIT, land on the CHECK cycle of processor p.
    task automatic run_to_check(input int p);
        instruction = 4'b0010;
        tick();
        instruction = 4'b0000;
        repeat (4 + p) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({ctl, proc_idx, indptr_addr, conn_idx, out_proc, out_startstop} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ctl=%b idx=%0d addr=%0d conn=%0d oproc=%0d oss=%b required all 0",
                     ctl, proc_idx, indptr_addr, conn_idx, out_proc, out_startstop);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_fire();
        clear_tables();
        instruction = 4'b0010;
        tick();
        instruction = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_ctl = 8'b01_1_0_0_0_0_0;
            n_cmp++;
            if (ctl !== exp_ctl || proc_idx !== PID_W'(i)) begin
                n_err++;
                $display("FAIL nofire_update[%0d]: got ctl=%b idx=%0d required ctl=%b idx=%0d", i, ctl, proc_idx, exp_ctl, i);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            exp_ctl = 8'b10_0_1_0_0_0_0;
            n_cmp++;
            if (ctl !== exp_ctl || proc_idx !== PID_W'(i)) begin
                n_err++;
                $display("FAIL nofire_check[%0d]: got ctl=%b idx=%0d required ctl=%b idx=%0d", i, ctl, proc_idx, exp_ctl, i);
            end
            tick();
        end
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_1) begin
            n_err++;
            $display("FAIL nofire_done: got ctl=%b required 00000001", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_0) begin
            n_err++;
            $display("FAIL nofire_idle: got ctl=%b required 00000000", ctl);
        end
    endtask

    task automatic test_fire_walk();
        clear_tables();
        indptr_mem[2] = 4'd3;
        indptr_mem[3] = 4'd6;
        indptr_mem[4] = 4'd6;
        ss_tbl[2] = 2'b01;
        run_to_check(2);
        n_cmp++;
        if (ctl !== 8'b10_0_1_0_0_0_0 || proc_idx !== 3'd2) begin
            n_err++;
            $display("FAIL fire_check_t: got ctl=%b idx=%0d required 10010000 idx=2", ctl, proc_idx);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b11_0_0_1_0_1_0 || indptr_addr !== 3'd2 || out_proc !== 3'd2 || out_startstop !== 2'b01) begin
            n_err++;
            $display("FAIL fire_t1: got ctl=%b addr=%0d oproc=%0d oss=%b required 11001010 addr=2 oproc=2 oss=01",
                     ctl, indptr_addr, out_proc, out_startstop);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b11_0_0_1_0_0_0 || indptr_addr !== 3'd3) begin
            n_err++;
            $display("FAIL fire_t2: got ctl=%b addr=%0d required 11001000 addr=3", ctl, indptr_addr);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b11_0_0_0_0_0_0) begin
            n_err++;
            $display("FAIL fire_t3: got ctl=%b required 11000000", ctl);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (ctl !== 8'b11_0_0_0_1_0_0 || conn_idx !== CID_W'(3 + k)) begin
                n_err++;
                $display("FAIL fire_conn[%0d]: got ctl=%b conn=%0d required 11000100 conn=%0d", k, ctl, conn_idx, 3 + k);
            end
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b10_0_1_0_0_0_0 || proc_idx !== 3'd3) begin
            n_err++;
            $display("FAIL fire_next_check: got ctl=%b idx=%0d required 10010000 idx=3", ctl, proc_idx);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_1) begin
            n_err++;
            $display("FAIL fire_done: got ctl=%b required 00000001", ctl);
        end
        tick();
    endtask

    task automatic test_empty_fanout();
        clear_tables();
        ss_tbl[0] = 2'b11;
        run_to_check(0);
        tick();
        n_cmp++;
        if (ctl !== 8'b11_0_0_1_0_1_0 || out_proc !== 3'd0 || out_startstop !== 2'b11) begin
            n_err++;
            $display("FAIL empty_t1: got ctl=%b oproc=%0d oss=%b required 11001010 oproc=0 oss=11", ctl, out_proc, out_startstop);
        end
        for (int c = 2; c < 4; c++) begin
            tick();
            n_cmp++;
            if (conn_rd_en !== 1'b0 || stage !== 2'b11) begin
                n_err++;
                $display("FAIL empty_t%0d: got conn_rd_en=%b stage=%b required 0 11", c, conn_rd_en, stage);
            end
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b10_0_1_0_0_0_0 || proc_idx !== 3'd1) begin
            n_err++;
            $display("FAIL empty_t4: got ctl=%b idx=%0d required 10010000 idx=1", ctl, proc_idx);
        end
        repeat (3) tick();
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_1) begin
            n_err++;
            $display("FAIL empty_done: got ctl=%b required 00000001", ctl);
        end
        tick();
    endtask

    task automatic test_last_clamp();
        clear_tables();
        indptr_mem[3] = 4'd10;
        indptr_mem[4] = 4'd15;
        ss_tbl[3] = 2'b10;
        run_to_check(3);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_proc !== 3'd3 || out_startstop !== 2'b10) begin
            n_err++;
            $display("FAIL clamp_event: got ov=%b oproc=%0d oss=%b required 1 3 10", out_valid, out_proc, out_startstop);
        end
        tick();
        n_cmp++;
        if (indptr_rd_en !== 1'b1 || indptr_addr !== 3'd4) begin
            n_err++;
            $display("FAIL clamp_hi_addr: got rd=%b addr=%0d required 1 4", indptr_rd_en, indptr_addr);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (ctl !== 8'b11_0_0_0_1_0_0 || conn_idx !== CID_W'(10 + k)) begin
                n_err++;
                $display("FAIL clamp_conn[%0d]: got ctl=%b conn=%0d required 11000100 conn=%0d", k, ctl, conn_idx, 10 + k);
            end
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_1) begin
            n_err++;
            $display("FAIL clamp_done: got ctl=%b required 00000001", ctl);
        end
        tick();
    endtask

    task automatic test_op_gating();
        logic [3:0] ops [0:3];
        logic [3:0] wops [0:3];
        logic [1:0] wexp [0:3];
        ops[0] = 4'b1100; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b1101;
        wops[0] = 4'b1100; wops[1] = 4'b0001; wops[2] = 4'b0100; wops[3] = 4'b1110;
        wexp[0] = 2'b10;   wexp[1] = 2'b01;   wexp[2] = 2'b00;   wexp[3] = 2'b10;
        clear_tables();
        instruction = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) begin
            instruction = ops[i];
            #1;
            n_cmp++;
            if ({prog_en, ext_input_en} !== 2'b00 || ctl !== 8'b01_1_0_0_0_0_0 || proc_idx !== PID_W'(i)) begin
                n_err++;
                $display("FAIL gate_update[%0d]: got strobes=%b ctl=%b idx=%0d required 00 01100000 idx=%0d",
                         i, {prog_en, ext_input_en}, ctl, proc_idx, i);
            end
            tick();
        end
        instruction = 4'b0010;
        repeat (4) tick();
        instruction = 4'b0000;
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_1) begin
            n_err++;
            $display("FAIL gate_round_done: got ctl=%b required 00000001", ctl);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            instruction = wops[i];
            #1;
            n_cmp++;
            if ({prog_en, ext_input_en} !== wexp[i] || stage !== 2'b00) begin
                n_err++;
                $display("FAIL gate_wait[%0d]: got strobes=%b stage=%b required %b 00", i, {prog_en, ext_input_en}, stage, wexp[i]);
            end
            tick();
        end
        instruction = 4'b0000;
    endtask

    task automatic test_reset_mid_walk();
        clear_tables();
        indptr_mem[2] = 4'd3;
        indptr_mem[3] = 4'd6;
        ss_tbl[2] = 2'b01;
        run_to_check(2);
        repeat (5) tick();
        n_cmp++;
        if (conn_rd_en !== 1'b1 || conn_idx !== 4'd4) begin
            n_err++;
            $display("FAIL midwalk_pre: got conn_rd_en=%b conn=%0d required 1 4", conn_rd_en, conn_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, proc_idx, indptr_addr, conn_idx, out_proc, out_startstop, prog_en, ext_input_en} !== 26'd0) begin
            n_err++;
            $display("FAIL midwalk_reset: got ctl=%b idx=%0d conn=%0d oproc=%0d oss=%b required all 0",
                     ctl, proc_idx, conn_idx, out_proc, out_startstop);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (ctl !== 8'b00_0_0_0_0_0_0) begin
            n_err++;
            $display("FAIL midwalk_after: got ctl=%b required 00000000", ctl);
        end
    endtask

    initial begin
        clear_tables();
        test_reset();
        test_no_fire();
        test_fire_walk();
        test_empty_fanout();
        test_last_clamp();
        test_op_gating();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
